// File: rtl/ic555_ctrl.sv
// Clocked control core of a 555 astable: comparators, SR state, drive and phase timing.
// Optional feature macro: IC555_CMP_FILTER_EN (FILT_LEN-sample comparator qualification).
module ic555_ctrl #(
    parameter real VCC      = 5.0,
    parameter int  CNT_W    = 16,
    parameter int  FILT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  real              vcap,
    output real              vdrv,
    output logic             out,
    output logic             dis,
    output logic [CNT_W-1:0] t_high,
    output logic [CNT_W-1:0] t_low,
    output logic             meas_valid,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam real VTH = VCC * 2.0 / 3.0;
    localparam real VTR = VCC / 3.0;

    typedef enum logic [1:0] {IDLE, CHARGE, DISCHARGE} state_t;

    state_t           state, state_nxt;
    logic             thr_hit, trg_hit;
    logic             thr_dec, trg_dec;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             first_done;

    if (FILT_LEN < 1) begin : g_filt_len_check
        $error("FILT_LEN must be at least 1");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign thr_hit = (vcap >= VTH);
    assign trg_hit = (vcap <= VTR);

`ifdef IC555_CMP_FILTER_EN
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [RUN_W-1:0] thr_run, trg_run;

    // A decision needs FILT_LEN consecutive hits; the run restarts on any miss or state change.
    assign thr_dec = thr_hit && (int'(thr_run) == FILT_LEN - 1);
    assign trg_dec = trg_hit && (int'(trg_run) == FILT_LEN - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_run <= '0;
            trg_run <= '0;
        end else begin
            if (state_nxt != state || state != CHARGE || !thr_hit)
                thr_run <= '0;
            else
                thr_run <= thr_run + RUN_W'(1);
            if (state_nxt != state || state != DISCHARGE || !trg_hit)
                trg_run <= '0;
            else
                trg_run <= trg_run + RUN_W'(1);
        end
    end
`else
    assign thr_dec = thr_hit;
    assign trg_dec = trg_hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = CHARGE;
                CHARGE:    if (thr_dec) state_nxt = DISCHARGE;
                DISCHARGE: if (trg_dec) state_nxt = CHARGE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    assign cnt_inc = sat_inc(cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            t_high     <= '0;
            t_low      <= '0;
            cycle_cnt  <= '0;
            meas_valid <= 1'b0;
            first_done <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (state_nxt == IDLE) begin
                cnt        <= '0;
                first_done <= 1'b0;
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (state_nxt != state) begin
                // Exit edge is counted; the next phase starts from zero and reads 1 on its first edge.
                cnt <= '0;
                if (state == CHARGE) begin
                    t_high <= cnt_inc;
                end else begin
                    t_low      <= cnt_inc;
                    cycle_cnt  <= sat_inc(cycle_cnt);
                    meas_valid <= first_done;
                    first_done <= 1'b1;
                end
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

    assign out  = (state == CHARGE);
    assign dis  = ~out;
    assign vdrv = out ? VCC : 0.0;

endmodule

// File: tb/tb_ic555_ctrl.sv
// Directed self-checking bench for ic555_ctrl, including a simple discrete RC loop model.
module tb_ic555_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    real         vcap = 0.0;
    real         vdrv, vdrv4;
    logic        out, dis, meas_valid;
    logic        out4, dis4, meas_valid4;
    logic [15:0] t_high, t_low, cycle_cnt;
    logic [3:0]  t_high4, t_low4, cycle_cnt4;

    int nerr = 0;
    int nchk = 0;

    ic555_ctrl #(.VCC(5.0), .CNT_W(16), .FILT_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vcap(vcap), .vdrv(vdrv), .out(out), .dis(dis),
        .t_high(t_high), .t_low(t_low), .meas_valid(meas_valid), .cycle_cnt(cycle_cnt)
    );

    ic555_ctrl #(.VCC(5.0), .CNT_W(4), .FILT_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .vcap(vcap), .vdrv(vdrv4), .out(out4), .dis(dis4),
        .t_high(t_high4), .t_low(t_low4), .meas_valid(meas_valid4), .cycle_cnt(cycle_cnt4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic longint mv(input real v);
        return longint'($rtoi(v * 1000.0));
    endfunction

    initial begin
        // Reset with inputs that would otherwise start the oscillator
        en   = 1'b1;
        vcap = 4.0;
        tick(2);
        check("rst_vdrv", mv(vdrv), 0);
        check("rst_out", out, 0);
        check("rst_dis", dis, 1);
        check("rst_thigh", t_high, 0);
        check("rst_tlow", t_low, 0);
        check("rst_cyc", cycle_cnt, 0);
        check("rst_mv", meas_valid, 0);
        vcap  = 2.0;
        rst_n = 1'b1;
        tick();
        check("start_out", out, 1);
        check("start_vdrv", mv(vdrv), 5000);
        check("start_dis", dis, 0);

`ifdef IC555_CMP_FILTER_EN
        vcap = 3.5;
        tick(3);
        check("filt_short", out, 1);
        vcap = 2.0;
        tick();
        check("filt_break", out, 1);
        vcap = 3.5;
        tick(3);
        check("filt_3rd", out, 1);
        tick();
        check("filt_4th", out, 0);
        check("filt_thigh", t_high, 8);
`else
        // First cycle from IDLE
        tick(5);
        vcap = 3.4;
        tick();
        check("c1_out", out, 0);
        check("c1_thigh", t_high, 6);
        tick(3);
        vcap = 1.6;
        tick();
        check("c1_out2", out, 1);
        check("c1_tlow", t_low, 4);
        check("c1_cyc", cycle_cnt, 1);
        check("c1_mv", meas_valid, 0);
        // Second cycle is steady-state
        vcap = 2.0;
        tick(2);
        vcap = 3.4;
        tick();
        check("c2_thigh", t_high, 3);
        tick();
        vcap = 1.6;
        tick();
        check("c2_tlow", t_low, 2);
        check("c2_cyc", cycle_cnt, 2);
        check("c2_mv", meas_valid, 1);
        vcap = 2.0;
        tick();
        check("c2_mv_pulse", meas_valid, 0);

        // Disable mid-CHARGE
        en = 1'b0;
        tick();
        check("off_out", out, 0);
        check("off_vdrv", mv(vdrv), 0);
        check("off_thigh", t_high, 3);
        check("off_tlow", t_low, 2);
        check("off_cyc", cycle_cnt, 2);
        tick(2);
        check("off_hold", out, 0);
        en = 1'b1;
        tick();
        check("on_out", out, 1);
        vcap = 3.4;
        tick();
        check("c3_thigh", t_high, 1);
        vcap = 1.6;
        tick();
        check("c3_tlow", t_low, 1);
        check("c3_cyc", cycle_cnt, 3);
        check("c3_mv", meas_valid, 0);

        // Long CHARGE: saturation in the 4-bit instance
        vcap = 2.0;
        tick(20);
        vcap = 3.4;
        tick();
        check("sat_thigh16", t_high, 21);
        check("sat_thigh4", t_high4, 15);
        check("sat_cyc4", cycle_cnt4, 3);

        // Comparator ignoring and exact thresholds
        vcap = 4.0;
        tick();
        check("dis_ign_thr", out, 0);
        vcap = 5.0 / 3.0 + 0.01;
        tick();
        check("trg_above", out, 0);
        vcap = 5.0 / 3.0;
        tick();
        check("trg_equal", out, 1);
        vcap = 0.5;
        tick();
        check("chg_ign_trg", out, 1);
        vcap = 10.0 / 3.0 - 0.01;
        tick();
        check("thr_below", out, 1);
        vcap = 10.0 / 3.0;
        tick();
        check("thr_equal", out, 0);

        // Asynchronous reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", out, 0);
        check("arst_thigh", t_high, 0);
        check("arst_cyc", cycle_cnt, 0);

        // Closed loop with discrete RC (tau = 10 clocks)
        vcap = 0.0;
        tick();
        rst_n = 1'b1;
        begin
            int nmeas = 0;
            int t0 = 0;
            for (int i = 0; i < 400 && nmeas < 2; i++) begin
                tick();
                if (meas_valid) begin
                    nmeas++;
                    if (nmeas == 1) begin
                        t0 = i;
                        check("loop_cyc1", cycle_cnt, 2);
                        check("loop_thigh", (t_high >= 6 && t_high <= 8), 1);
                        check("loop_tlow", (t_low >= 6 && t_low <= 8), 1);
                    end else begin
                        check("loop_cyc2", cycle_cnt, 3);
                        check("loop_period", (i - t0 >= 12 && i - t0 <= 16), 1);
                    end
                end
                vcap = vcap + (vdrv - vcap) * 0.1;
            end
            if (nmeas < 2) check("loop_timeout", nmeas, 2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
